buzzer_arbiter_module: RTL and testbench
========================================

// Module: buzzer_arbiter_module
// PURPOSE
//  Shares the single board buzzer between three independent beep requesters
//  (e.g. SOS pattern, key-click, alarm) using round-robin arbitration.
//  Each granted request gets a timed square-wave tone, followed by a silent gap.
//  Drives the active-low buzzer pin directly; sits between requesters and pad.
// PARAMETERS
//  MS_DIV    50000  clocks per 1 ms tick (50 MHz CLK)
//  TONE_DIV  12500  clocks per tone half-period (2 kHz tone)
//  GAP_MS    50     silent gap after every grant, in ms (>=1)
// PORTS
//  CLK        in   1   system clock, single domain
//  RSTn       in   1   asynchronous active-low reset
//  Req_Sig    in   3   level requests; held high until Done_Sig for that bit
//  Dur_Bus    in   48  tone length in ms; Dur_Bus[16k+15:16k] for requester k
//  Grant_Sig  out  3   one-hot grant, high for whole TONE phase of winner
//  Done_Sig   out  3   one-cycle pulse on bit k when k's tone completes
//  Busy_Sig   out  1   high in TONE and GAP states
//  Pin_Out    out  1   buzzer drive, active-low (low = tone phase on)
// BEHAVIOUR
//  - Reset: state IDLE, Grant=0, Done=0, Busy=0, Pin_Out=1, rr pointer=0,
//    all counters 0. Reset mid-tone silences buzzer immediately (async).
//  - All outputs registered. States: IDLE -> TONE -> GAP -> IDLE.
//  - IDLE: if any Req bit high at edge N, pick first set bit searching from
//    rr pointer upward (mod 3); at edge N Grant[k]=1, Busy=1, Dur latched
//    from Dur_Bus slice k, ms/tone counters cleared, state=TONE.
//  - After grant of k, rr pointer = (k+1) mod 3 (served requester lowest next).
//  - TONE: lasts exactly Dur*MS_DIV clocks. Pin_Out low for first TONE_DIV
//    clocks, then toggles every TONE_DIV clocks. On last TONE clock edge:
//    Grant=0, Done[k]=1 for one cycle, Pin_Out=1, state=GAP.
//  - Dur=0: TONE lasts one clock, Pin_Out stays high, Done[k] still pulses.
//  - Dur field is 16-bit; ms counter 16-bit, no wrap (max 65535 ms).
//  - Req[k] dropped during TONE: abort at next edge -> Grant=0, Pin_Out=1,
//    no Done pulse, state=GAP (gap still enforced).
//  - Changes on Dur_Bus or other Req bits during TONE/GAP are ignored.
//  - GAP: GAP_MS*MS_DIV clocks, Pin_Out=1, Grant=0; then IDLE, Busy=0.
//    IDLE lasts >=1 clock before next grant.
//  - Simultaneous requests resolved by rr pointer only; no starvation: each
//    continuously requesting bit is served within 3 grants.
//  - Grant and Done never both high for the same bit in the same cycle.
// TESTING (sim params MS_DIV=4, TONE_DIV=2, GAP_MS=1)
//  1 Reset release, Req=000 -> Pin_Out=1, Grant=000, Busy=0 for 100 clocks.
//  2 Req=001, Dur0=3 -> Grant=001 for 12 clocks, Pin_Out 0,0,1,1,... pattern,
//    Done[0] pulse on 12th, then 4 gap clocks Pin_Out=1, Busy drops.
//  3 Req=111 held, all Dur=1 -> grants 001,010,100,001 in order, each 4
//    clocks with 4-clock gap and >=1 IDLE clock between.
//  4 Req=010, Dur1=0 -> Grant=010 one clock, Done[1] pulse, Pin_Out never 0.
//  5 Req=100, Dur2=5; drop Req[2] after 6 clocks -> Grant clears next edge,
//    no Done pulse, 4-clock gap, IDLE.
//  6 Assert RSTn=0 mid-TONE -> Pin_Out=1, Grant=000 immediately; after release
//    pending Req=001 re-granted from rr pointer 0.

Source files
------------

// File: rtl/buzzer_arbiter_module.sv
// buzzer_arbiter_module
// Round-robin sharing of one active-low buzzer pad between three requesters.
// A grant plays a square-wave tone for the requested number of milliseconds,
// then the buzzer is forced silent for a fixed gap before the next grant.
// All outputs come straight from flops so the pad sees no combinational glitches.

module buzzer_arbiter_module #(
   parameter int MS_DIV   = 50000,  // clocks per 1 ms tick
   parameter int TONE_DIV = 12500,  // clocks per tone half-period
   parameter int GAP_MS   = 50      // silent gap after every grant, in ms (>=1)
) (
   input  logic        CLK,
   input  logic        RSTn,
   input  logic [2:0]  Req_Sig,
   input  logic [47:0] Dur_Bus,
   output logic [2:0]  Grant_Sig,
   output logic [2:0]  Done_Sig,
   output logic        Busy_Sig,
   output logic        Pin_Out
);

   // Counter widths; a divider of 1 still needs a 1-bit counter.
   localparam int DIV_W  = (MS_DIV   > 1) ? $clog2(MS_DIV)   : 1;
   localparam int HALF_W = (TONE_DIV > 1) ? $clog2(TONE_DIV) : 1;

   // Terminal counts, pre-sized to the counters they are compared against.
   localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(MS_DIV - 1);
   localparam logic [HALF_W-1:0] HALF_LAST = HALF_W'(TONE_DIV - 1);
   localparam logic [15:0]       GAP_LAST  = 16'(GAP_MS - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_TONE = 2'd1,
      ST_GAP  = 2'd2
   } state_t;

   // Registered state and its next-state values.
   state_t            state_q, state_d;
   logic [1:0]        rr_q,    rr_d;     // requester searched first on the next grant
   logic [1:0]        idx_q,   idx_d;    // index of the requester currently served
   logic [15:0]       dur_q,   dur_d;    // latched tone length in ms
   logic [15:0]       ms_q,    ms_d;     // whole ms elapsed in TONE or GAP
   logic [DIV_W-1:0]  div_q,   div_d;    // clocks within the current ms
   logic [HALF_W-1:0] half_q,  half_d;   // clocks within the current tone half-period
   logic [2:0]        grant_q, grant_d;
   logic [2:0]        done_q,  done_d;
   logic              busy_q,  busy_d;
   logic              pin_q,   pin_d;

   // Arbiter and decode helpers.
   logic [1:0]        cand0, cand1, cand2;
   logic [1:0]        pick;
   logic [2:0]        pick_onehot;
   logic [15:0]       pick_dur;
   logic              req_held;
   logic              ms_tick;
   logic              tone_last;
   logic              gap_last;

   // Modulo-3 increment of a requester index.
   function automatic logic [1:0] inc3(input logic [1:0] x);
      return (x == 2'd2) ? 2'd0 : x + 2'd1;
   endfunction

   // Selects one request bit by index without an out-of-range read.
   function automatic logic req_bit(input logic [2:0] v, input logic [1:0] i);
      case (i)
         2'd0:    return v[0];
         2'd1:    return v[1];
         default: return v[2];
      endcase
   endfunction

   // Selects the 16-bit duration field belonging to requester i.
   function automatic logic [15:0] dur_field(input logic [47:0] bus, input logic [1:0] i);
      case (i)
         2'd0:    return bus[15:0];
         2'd1:    return bus[31:16];
         default: return bus[47:32];
      endcase
   endfunction

   // Converts a requester index to its one-hot grant vector.
   function automatic logic [2:0] onehot3(input logic [1:0] i);
      case (i)
         2'd0:    return 3'b001;
         2'd1:    return 3'b010;
         default: return 3'b100;
      endcase
   endfunction

   // Round-robin search: first set request starting at the pointer, wrapping mod 3.
   always_comb begin
      cand0 = rr_q;
      cand1 = inc3(cand0);
      cand2 = inc3(cand1);
      if (req_bit(Req_Sig, cand0)) begin
         pick = cand0;
      end else if (req_bit(Req_Sig, cand1)) begin
         pick = cand1;
      end else begin
         pick = cand2;
      end
      pick_onehot = onehot3(pick);
      pick_dur    = dur_field(Dur_Bus, pick);
   end

   // Terminal-count decodes for the shared ms timer used by both TONE and GAP.
   always_comb begin
      req_held  = req_bit(Req_Sig, idx_q);
      ms_tick   = (div_q == DIV_LAST);
      // A zero duration ends TONE after its single clock; otherwise the last
      // clock is the final divider count of the final millisecond.
      tone_last = (dur_q == 16'd0) || (ms_tick && (ms_q == dur_q - 16'd1));
      gap_last  = ms_tick && (ms_q == GAP_LAST);
   end

   // Next-state logic for the IDLE -> TONE -> GAP -> IDLE sequence and all outputs.
   always_comb begin
      state_d = state_q;
      rr_d    = rr_q;
      idx_d   = idx_q;
      dur_d   = dur_q;
      ms_d    = ms_q;
      div_d   = div_q;
      half_d  = half_q;
      grant_d = grant_q;
      done_d  = 3'b000;
      busy_d  = busy_q;
      pin_d   = pin_q;

      case (state_q)
         ST_IDLE: begin
            if (|Req_Sig) begin
               state_d = ST_TONE;
               idx_d   = pick;
               rr_d    = inc3(pick);
               dur_d   = pick_dur;
               grant_d = pick_onehot;
               busy_d  = 1'b1;
               ms_d    = 16'd0;
               div_d   = '0;
               half_d  = '0;
               // A zero-length tone never drives the pad.
               pin_d   = (pick_dur == 16'd0);
            end
         end

         ST_TONE: begin
            if (!req_held) begin
               // Requester withdrew: silence now, no Done, but still enforce the gap.
               state_d = ST_GAP;
               grant_d = 3'b000;
               pin_d   = 1'b1;
               ms_d    = 16'd0;
               div_d   = '0;
            end else if (tone_last) begin
               state_d = ST_GAP;
               grant_d = 3'b000;
               done_d  = grant_q;
               pin_d   = 1'b1;
               ms_d    = 16'd0;
               div_d   = '0;
            end else begin
               if (ms_tick) begin
                  div_d = '0;
                  ms_d  = ms_q + 16'd1;
               end else begin
                  div_d = div_q + 1'b1;
               end
               if (half_q == HALF_LAST) begin
                  half_d = '0;
                  pin_d  = ~pin_q;
               end else begin
                  half_d = half_q + 1'b1;
               end
            end
         end

         ST_GAP: begin
            if (gap_last) begin
               state_d = ST_IDLE;
               busy_d  = 1'b0;
               ms_d    = 16'd0;
               div_d   = '0;
            end else if (ms_tick) begin
               div_d = '0;
               ms_d  = ms_q + 16'd1;
            end else begin
               div_d = div_q + 1'b1;
            end
         end

         default: begin
            state_d = ST_IDLE;
            grant_d = 3'b000;
            busy_d  = 1'b0;
            pin_d   = 1'b1;
         end
      endcase
   end

   // State and output registers; reset silences the pad without waiting for a clock.
   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         state_q <= ST_IDLE;
         rr_q    <= 2'd0;
         idx_q   <= 2'd0;
         dur_q   <= 16'd0;
         ms_q    <= 16'd0;
         div_q   <= '0;
         half_q  <= '0;
         grant_q <= 3'b000;
         done_q  <= 3'b000;
         busy_q  <= 1'b0;
         pin_q   <= 1'b1;
      end else begin
         state_q <= state_d;
         rr_q    <= rr_d;
         idx_q   <= idx_d;
         dur_q   <= dur_d;
         ms_q    <= ms_d;
         div_q   <= div_d;
         half_q  <= half_d;
         grant_q <= grant_d;
         done_q  <= done_d;
         busy_q  <= busy_d;
         pin_q   <= pin_d;
      end
   end

   assign Grant_Sig = grant_q;
   assign Done_Sig  = done_q;
   assign Busy_Sig  = busy_q;
   assign Pin_Out   = pin_q;

endmodule

// File: tb/tb_buzzer_arbiter_module.sv
// tb_buzzer_arbiter_module
// Directed bench for buzzer_arbiter_module with MS_DIV=4, TONE_DIV=2, GAP_MS=1.
// Inputs change on the falling edge; outputs are sampled 1 time unit after the rising edge.

module tb_buzzer_arbiter_module;

   logic        CLK = 1'b0;
   logic        RSTn;
   logic [2:0]  Req_Sig;
   logic [47:0] Dur_Bus;
   logic [2:0]  Grant_Sig;
   logic [2:0]  Done_Sig;
   logic        Busy_Sig;
   logic        Pin_Out;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 CLK = ~CLK;

   buzzer_arbiter_module #(
      .MS_DIV   (4),
      .TONE_DIV (2),
      .GAP_MS   (1)
   ) dut (
      .CLK       (CLK),
      .RSTn      (RSTn),
      .Req_Sig   (Req_Sig),
      .Dur_Bus   (Dur_Bus),
      .Grant_Sig (Grant_Sig),
      .Done_Sig  (Done_Sig),
      .Busy_Sig  (Busy_Sig),
      .Pin_Out   (Pin_Out)
   );

   typedef struct {
      logic [2:0]  req;
      logic [47:0] dur;
      logic [2:0]  grant;
      logic [2:0]  done;
      logic        busy;
      logic        pin;
   } vec_t;

   vec_t tbl[$];

   function automatic logic [47:0] durs(input logic [15:0] d2, input logic [15:0] d1,
                                        input logic [15:0] d0);
      return {d2, d1, d0};
   endfunction

   task automatic add(input logic [2:0] req, input logic [47:0] dur, input logic [2:0] g,
                      input logic [2:0] d, input logic b, input logic p);
      vec_t v;
      v.req = req; v.dur = dur; v.grant = g; v.done = d; v.busy = b; v.pin = p;
      tbl.push_back(v);
   endtask

   task automatic check(input string name, input logic [2:0] g, input logic [2:0] d,
                        input logic b, input logic p);
      n_tests++;
      if ({Grant_Sig, Done_Sig, Busy_Sig, Pin_Out} !== {g, d, b, p}) begin
         n_fail++;
         $display("FAIL %s: got grant=%b done=%b busy=%b pin=%b, want grant=%b done=%b busy=%b pin=%b",
                  name, Grant_Sig, Done_Sig, Busy_Sig, Pin_Out, g, d, b, p);
      end
   endtask

   // Apply inputs on the falling edge, then sample just after the next rising edge.
   task automatic cyc(input logic [2:0] req, input logic [47:0] dur);
      @(negedge CLK);
      Req_Sig = req;
      Dur_Bus = dur;
      @(posedge CLK);
      #1;
   endtask

   initial begin
      logic [2:0] ord [4];
      logic [47:0] d2v, d4v;
      int k, ph;

      ord[0] = 3'b001; ord[1] = 3'b010; ord[2] = 3'b100; ord[3] = 3'b001;

      // Table: single request bit 0 with Dur0=3, then bit 1 with Dur1=0.
      d2v = durs(16'd0, 16'd0, 16'd3);
      for (int i = 0; i < 12; i++) add(3'b001, d2v, 3'b001, 3'b000, 1'b1, ((i / 2) % 2) == 1);
      add(3'b001, d2v, 3'b000, 3'b001, 1'b1, 1'b1);
      for (int i = 0; i < 3; i++) add(3'b000, d2v, 3'b000, 3'b000, 1'b1, 1'b1);
      add(3'b000, d2v, 3'b000, 3'b000, 1'b0, 1'b1);
      add(3'b000, d2v, 3'b000, 3'b000, 1'b0, 1'b1);
      d4v = durs(16'd0, 16'd0, 16'd0);
      add(3'b010, d4v, 3'b010, 3'b000, 1'b1, 1'b1);
      add(3'b010, d4v, 3'b000, 3'b010, 1'b1, 1'b1);
      for (int i = 0; i < 3; i++) add(3'b000, d4v, 3'b000, 3'b000, 1'b1, 1'b1);
      add(3'b000, d4v, 3'b000, 3'b000, 1'b0, 1'b1);

      // Reset state, then 100 idle clocks with no requests.
      RSTn    = 1'b0;
      Req_Sig = 3'b000;
      Dur_Bus = '0;
      repeat (3) @(posedge CLK);
      #1;
      check("reset_state", 3'b000, 3'b000, 1'b0, 1'b1);
      @(negedge CLK);
      RSTn = 1'b1;
      for (int i = 0; i < 100; i++) begin
         cyc(3'b000, '0);
         check($sformatf("idle%0d", i), 3'b000, 3'b000, 1'b0, 1'b1);
      end

      // All three requesting continuously, Dur=1 each: 9-clock grant period.
      for (int j = 0; j < 36; j++) begin
         cyc(3'b111, durs(16'd1, 16'd1, 16'd1));
         k  = j / 9;
         ph = j % 9;
         check($sformatf("rr_j%0d", j),
               (ph < 4) ? ord[k] : 3'b000,
               (ph == 4) ? ord[k] : 3'b000,
               ph != 8,
               ph >= 2);
      end
      cyc(3'b000, '0);
      check("rr_end_idle", 3'b000, 3'b000, 1'b0, 1'b1);

      // Table-driven vectors.
      for (int i = 0; i < tbl.size(); i++) begin
         cyc(tbl[i].req, tbl[i].dur);
         check($sformatf("vec%0d", i), tbl[i].grant, tbl[i].done, tbl[i].busy, tbl[i].pin);
      end

      // Abort: Req[2] with Dur2=5 dropped after 6 clocks; Dur_Bus changed mid-tone.
      for (int j = 0; j < 6; j++) begin
         cyc(3'b100, (j == 0) ? durs(16'd5, 16'd0, 16'd0) : durs(16'd1, 16'd0, 16'd0));
         check($sformatf("abort_tone%0d", j), 3'b100, 3'b000, 1'b1, ((j / 2) % 2) == 1);
      end
      cyc(3'b000, '0);
      check("abort_drop", 3'b000, 3'b000, 1'b1, 1'b1);
      for (int j = 0; j < 3; j++) begin
         cyc(3'b000, '0);
         check($sformatf("abort_gap%0d", j), 3'b000, 3'b000, 1'b1, 1'b1);
      end
      cyc(3'b000, '0);
      check("abort_idle", 3'b000, 3'b000, 1'b0, 1'b1);

      // Async reset mid-tone; pointer is left at 1 beforehand so 011 shows it returned to 0.
      cyc(3'b001, durs(16'd0, 16'd0, 16'd4));
      check("rst_pre_tone0", 3'b001, 3'b000, 1'b1, 1'b0);
      cyc(3'b001, durs(16'd0, 16'd0, 16'd4));
      check("rst_pre_tone1", 3'b001, 3'b000, 1'b1, 1'b0);
      @(negedge CLK);
      #2;
      RSTn = 1'b0;
      #1;
      check("rst_async", 3'b000, 3'b000, 1'b0, 1'b1);
      @(posedge CLK);
      #1;
      check("rst_held", 3'b000, 3'b000, 1'b0, 1'b1);
      @(negedge CLK);
      Req_Sig = 3'b011;
      Dur_Bus = durs(16'd0, 16'd1, 16'd1);
      RSTn    = 1'b1;
      @(posedge CLK);
      #1;
      check("rst_regrant", 3'b001, 3'b000, 1'b1, 1'b0);

      cyc(3'b000, '0);
      repeat (6) @(posedge CLK);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
